// File: rtl/riscv_dec_pkg.sv
// Shared RISC-V decode definitions: opcode constants, instruction-type codes,
// immediate formats and control-word field positions.
package riscv_dec_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        IT_LOAD    = 4'd0,
        IT_IMM     = 4'd1,
        IT_STORE   = 4'd2,
        IT_REG     = 4'd3,
        IT_LUI     = 4'd4,
        IT_AUIPC   = 4'd5,
        IT_BRANCH  = 4'd6,
        IT_JALR    = 4'd7,
        IT_JAL     = 4'd8,
        IT_ILLEGAL = 4'hF
    } inst_type_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Control word layout
    localparam int CW_W        = 23;
    localparam int CW_TYPE_LSB = 0;   // [3:0]   instType
    localparam int CW_FUN3_LSB = 4;   // [6:4]   fun3
    localparam int CW_FUN7_BIT = 7;   // [7]     inst[30]
    localparam int CW_RD_LSB   = 8;   // [12:8]  rd
    localparam int CW_RS1_LSB  = 13;  // [17:13] rs1
    localparam int CW_RS2_LSB  = 18;  // [22:18] rs2

endpackage

// File: rtl/decode_core.sv
// Purely combinational RISC-V instruction decoder.
// Ports:
//   i_inst    - raw 32-bit instruction word
//   o_cword   - packed control word (type, fun3, fun7, rd, rs1, rs2)
//   o_imm     - immediate, sign-extended from inst[31] to XLEN
//   o_illegal - opcode not recognised or inst[1:0] != 2'b11
module decode_core
    import riscv_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      i_inst,
    output logic [CW_W-1:0]  o_cword,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_illegal
);

    inst_type_e  w_type;
    imm_fmt_e    w_fmt;
    logic [31:0] w_imm32;

    always_comb begin
        w_type = IT_ILLEGAL;
        w_fmt  = IMM_NONE;
        if (i_inst[1:0] == 2'b11) begin
            case (i_inst[6:0])
                OPC_LOAD:   begin w_type = IT_LOAD;   w_fmt = IMM_I; end
                OPC_IMM:    begin w_type = IT_IMM;    w_fmt = IMM_I; end
                OPC_STORE:  begin w_type = IT_STORE;  w_fmt = IMM_S; end
                OPC_REG:    begin w_type = IT_REG;    w_fmt = IMM_NONE; end
                OPC_LUI:    begin w_type = IT_LUI;    w_fmt = IMM_U; end
                OPC_AUIPC:  begin w_type = IT_AUIPC;  w_fmt = IMM_U; end
                OPC_BRANCH: begin w_type = IT_BRANCH; w_fmt = IMM_B; end
                OPC_JALR:   begin w_type = IT_JALR;   w_fmt = IMM_I; end
                OPC_JAL:    begin w_type = IT_JAL;    w_fmt = IMM_J; end
                default:    begin w_type = IT_ILLEGAL; w_fmt = IMM_NONE; end
            endcase
        end
    end

    // 32-bit immediate first; widened to XLEN by a signed cast below.
    always_comb begin
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            IMM_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            IMM_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_inst[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    always_comb begin
        o_cword                          = '0;
        o_cword[CW_TYPE_LSB +: 4]        = w_type;
        o_cword[CW_FUN3_LSB +: 3]        = i_inst[14:12];
        o_cword[CW_FUN7_BIT]             = i_inst[30];
        o_cword[CW_RD_LSB   +: 5]        = i_inst[11:7];
        o_cword[CW_RS1_LSB  +: 5]        = i_inst[19:15];
        o_cword[CW_RS2_LSB  +: 5]        = i_inst[24:20];
        o_imm                            = XLEN'($signed(w_imm32));
        o_illegal                        = (w_type == IT_ILLEGAL);
    end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: valid/ready buffering around decode_core.
// Ports:
//   clk, rst         - clock (rising edge), async active-high reset
//   flush            - discard held and incoming instructions
//   in_valid/in_ready, in_inst, in_pc     - upstream handshake and payload
//   out_valid/out_ready                   - downstream handshake
//   out_cword, out_imm, out_pc, out_illegal - registered decoded entry
// SKID=1 adds a second entry so in_ready can be a pure register output;
// SKID=0 uses a single output register with a combinational in_ready.
module decode_stage
    import riscv_dec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_cword,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal
);

    typedef struct packed {
        logic [CW_W-1:0] cword;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t r_out;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_skid_valid;

    entry_t w_dec;
    logic   w_in_xfer;
    logic   w_out_free;

    decode_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_inst    (in_inst),
        .o_cword   (w_dec.cword),
        .o_imm     (w_dec.imm),
        .o_illegal (w_dec.illegal)
    );

    assign w_dec.pc   = in_pc;
    assign w_in_xfer  = in_valid && in_ready;
    // Output slot can take a new entry this edge
    assign w_out_free = !r_out_valid || out_ready;

    assign in_ready   = (SKID != 0) ? !r_skid_valid : w_out_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // Skid entry is older than anything arriving, so it drains first;
            // in_ready is low while it is held, so no input collides with it.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_in_xfer && (SKID != 0)) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_cword   = r_out.cword;
    assign out_imm     = r_out.imm;
    assign out_pc      = r_out.pc;
    assign out_illegal = r_out.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of pc and immediate (32 or 64).
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer; 0 = single output register.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  in  1  discard all held and incoming instructions.
REQ-006 SHALL have port in_valid  in  1  upstream instruction present.
REQ-007 SHALL have port in_ready  out  1  stage can accept.
REQ-008 SHALL have port in_inst  in  32  raw instruction word.
REQ-009 SHALL have port in_pc  in  XLEN  instruction address.
REQ-010 SHALL have port out_valid  out  1  decoded entry present.
REQ-011 SHALL have port out_ready  in  1  downstream accepts.
REQ-012 SHALL have port out_cword  out  23  control word: [3:0] instType, [6:4] fun3, [7] fun7 (inst[30]), [12:8] rd, [17:13] rs1, [22:18] rs2.
REQ-013 SHALL have port out_imm  out  XLEN  sign-extended immediate.
REQ-014 SHALL have port out_pc  out  XLEN  pc of the entry.
REQ-015 SHALL have port out_illegal  out  1  entry is an illegal instruction.

Function
REQ-016 Transfer SHALL occur on a rising edge with valid&&ready on the respective side; 1-cycle latency from input transfer to out_valid.
REQ-017 instType SHALL decode from inst[6:0]: 0000011=0 load, 0010011=1 imm, 0100011=2 store, 0110011=3 reg, 0110111=4 lui, 0010111=5 auipc, 1100011=6 branch, 1100111=7 jalr, 1101111=8 jal.
REQ-018 Any other opcode, or inst[1:0]!=2'b11, SHALL give instType 4'hF and out_illegal=1; field slices still passed through.
REQ-019 Immediate SHALL be I-type for load/imm/jalr, S for store, B for branch, U for lui/auipc (inst[31:12]<<12), J for jal, 0 for reg and illegal; all sign-extended from inst[31] to XLEN.
REQ-020 Outputs SHALL come directly from registers; no combinational path in_* -> out_*.
REQ-021 SKID=1: in_ready SHALL be registered, low only when the skid entry is occupied; entry order preserved; full throughput 1/cycle with out_ready high.
REQ-022 SKID=1: if the output register is full and out_ready is low on an input transfer, the new entry SHALL go to the skid slot; when out_ready rises, skid moves to output the same edge.
REQ-023 SKID=0: in_ready SHALL equal !out_valid || out_ready.
REQ-024 Simultaneous output transfer and input transfer SHALL keep out_valid high, with the next entry loaded.
REQ-025 flush SHALL, at the next edge, clear out_valid and the skid slot and drop any same-cycle input; flush overrides in_valid and out_ready; in_ready SHALL be 1 the following cycle.
REQ-026 out_* data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-027 On rst assertion, out_valid=0, skid empty, in_ready=1 (after reset), out_cword=0, out_imm=0, out_pc=0, out_illegal=0, immediately and asynchronously.
REQ-028 Reset mid-stall SHALL discard all held entries; no entry emerges after deassertion.

Structure
REQ-029 Opcode constants, instType codes (0-8, 4'hF) and cword field positions SHALL live in shared package riscv_dec_pkg.
REQ-030 Combinational decode (cword, imm, illegal) SHALL be sub-module decode_core; decode_stage holds only buffering and handshake.

Verification
REQ-031 0xFFF10093 (addi x1,x2,-1) -> instType 1, rd 1, rs1 2, fun3 0, imm 0xFFFFFFFF (XLEN=32), out_valid next cycle.
REQ-032 0x008000EF (jal x1,8) -> instType 8, rd 1, imm 8; 0xFE000EE3 (beq x0,x0,-4) -> instType 6, imm 0xFFFFFFFC.
REQ-033 0x00000000 and 0x0000007F -> out_illegal 1, instType 4'hF, imm 0.
REQ-034 SKID=1, out_ready low, stream 3 instrs -> 2 accepted, in_ready low after 2nd; raise out_ready -> emerge in order, 1 per cycle.
REQ-035 flush with 2 held entries and in_valid high -> out_valid 0 next cycle, nothing later emerges, in_ready 1.
REQ-036 rst asserted mid-stall between edges -> out_valid 0 immediately; XLEN=64 run of REQ-031 -> imm 0xFFFFFFFFFFFFFFFF.
